// File: rtl/mera_bus_pkg.sv
// Shared system-bus definitions: answer codes, arbiter states, default timeout
// and small helpers used by the bus arbiter.
package mera_bus_pkg;

  localparam logic [1:0] ANS_OK  = 2'd0;
  localparam logic [1:0] ANS_EN  = 2'd1;
  localparam logic [1:0] ANS_PE  = 2'd2;
  localparam logic [1:0] ANS_TMO = 2'd3;

  localparam logic [7:0] TMO_DEFAULT = 8'd200;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_WAIT  = 2'd2,
    ST_REL   = 2'd3
  } state_e;

  // Parity error dominates "absent", which dominates a plain OK.
  function automatic logic [1:0] ans_sel(input logic pe, input logic en);
    logic [1:0] code;
    if (pe) begin
      code = ANS_PE;
    end else if (en) begin
      code = ANS_EN;
    end else begin
      code = ANS_OK;
    end
    return code;
  endfunction

  function automatic logic [2:0] oh2idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (oh[i]) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/sysbus_arb_rr_pick.sv
// Combinational round-robin picker: scans requests starting one past the
// pointer, wrapping modulo N, and returns a one-hot winner plus valid.
module rr_pick
  import mera_bus_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   ptr,
  output logic [N-1:0] gnt,
  output logic         valid
);

  logic found_s;

  // First requester found in pointer+1 .. pointer order wins.
  always_comb begin
    gnt     = '0;
    found_s = 1'b0;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (int'(ptr) + k) % N;
      if (!found_s && req[idx]) begin
        gnt[idx] = 1'b1;
        found_s  = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign valid = found_s;

endmodule

// File: rtl/sysbus_arb.sv
// System bus arbiter and cycle sequencer: grants the bus to the CPU or one of
// NCH channels, waits for OK/EN/PE or timeout, reports done/ans, then releases.
// Optional bus locking for read-modify-write is enabled by SYSBUS_ARB_LOCK_EN.
module sysbus_arb
  import mera_bus_pkg::*;
#(
  parameter int         NCH      = 4,
  parameter logic [7:0] TMO      = TMO_DEFAULT,
  parameter bit         CPU_LAST = 1'b1
) (
  input  logic           __clk,
  input  logic           __rst,
  input  logic           cpu_req,
  input  logic [NCH-1:0] ch_req,
  input  logic           bus_ok,
  input  logic           bus_en,
  input  logic           bus_pe,
`ifdef SYSBUS_ARB_LOCK_EN
  input  logic           lock,
`endif
  output logic           gnt_cpu,
  output logic [NCH-1:0] gnt_ch,
  output logic           bus_busy,
  output logic           done,
  output logic [1:0]     ans,
  output logic           alarm
);

  state_e         state_r, state_nxt_s;
  logic [7:0]     cnt_r, cnt_nxt_s;
  logic [2:0]     ptr_r, ptr_nxt_s;
  logic           own_cpu_r, own_cpu_nxt_s;
  logic [NCH-1:0] own_ch_r, own_ch_nxt_s;
  logic           gnt_cpu_r, gnt_cpu_nxt_s;
  logic [NCH-1:0] gnt_ch_r, gnt_ch_nxt_s;
  logic           busy_r, busy_nxt_s;
  logic           done_r, done_nxt_s;
  logic [1:0]     ans_r, ans_nxt_s;
  logic           alarm_r, alarm_nxt_s;

  logic [NCH-1:0] win_s;
  logic [7:0]     win8_s;
  logic           win_vld_s;
  logic           any_ans_s, owner_req_s, tmo_hit_s;
  logic           pick_cpu_s, pick_ch_s, relock_s;

  rr_pick #(.N(NCH)) u_pick (
    .req   (ch_req),
    .ptr   (ptr_r),
    .gnt   (win_s),
    .valid (win_vld_s)
  );

  // Zero-extend the channel winner so the index helper works for any NCH.
  always_comb begin
    win8_s           = 8'd0;
    win8_s[NCH-1:0]  = win_s;
  end

  assign any_ans_s   = bus_ok | bus_en | bus_pe;
  assign owner_req_s = (own_cpu_r & cpu_req) | (|(own_ch_r & ch_req));
  assign tmo_hit_s   = ((cnt_r + 8'd1) == TMO);
  assign pick_cpu_s  = cpu_req & (~win_vld_s | ~CPU_LAST);
  assign pick_ch_s   = win_vld_s & ~pick_cpu_s;

`ifdef SYSBUS_ARB_LOCK_EN
  // A timed-out cycle never keeps the bus, even under lock.
  assign relock_s = lock & owner_req_s & ~any_ans_s & (ans_r != ANS_TMO);
`else
  assign relock_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge __clk) begin
    if (__rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cpu_req || win_vld_s) begin
          state_nxt_s = ST_GRANT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GRANT: state_nxt_s = ST_WAIT;
      ST_WAIT: begin
        if (any_ans_s || tmo_hit_s) begin
          state_nxt_s = ST_REL;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_REL: begin
        if (relock_s) begin
          state_nxt_s = ST_GRANT;
        end else if (!owner_req_s && !any_ans_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_REL;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, owner, pointer and timeout counter.
  always_comb begin
    gnt_cpu_nxt_s = gnt_cpu_r;
    gnt_ch_nxt_s  = gnt_ch_r;
    busy_nxt_s    = busy_r;
    done_nxt_s    = 1'b0;
    ans_nxt_s     = ans_r;
    alarm_nxt_s   = alarm_r;
    cnt_nxt_s     = cnt_r;
    ptr_nxt_s     = ptr_r;
    own_cpu_nxt_s = own_cpu_r;
    own_ch_nxt_s  = own_ch_r;
    case (state_r)
      ST_IDLE: begin
        if (pick_cpu_s) begin
          gnt_cpu_nxt_s = 1'b1;
          gnt_ch_nxt_s  = '0;
          own_cpu_nxt_s = 1'b1;
          own_ch_nxt_s  = '0;
          busy_nxt_s    = 1'b1;
        end else if (pick_ch_s) begin
          gnt_cpu_nxt_s = 1'b0;
          gnt_ch_nxt_s  = win_s;
          own_cpu_nxt_s = 1'b0;
          own_ch_nxt_s  = win_s;
          ptr_nxt_s     = oh2idx(win8_s);
          busy_nxt_s    = 1'b1;
        end else begin
          busy_nxt_s = 1'b0;
        end
      end
      ST_GRANT: cnt_nxt_s = 8'd0;
      ST_WAIT: begin
        cnt_nxt_s = cnt_r + 8'd1;
        if (any_ans_s) begin
          done_nxt_s    = 1'b1;
          ans_nxt_s     = ans_sel(bus_pe, bus_en);
          gnt_cpu_nxt_s = 1'b0;
          gnt_ch_nxt_s  = '0;
        end else if (tmo_hit_s) begin
          done_nxt_s    = 1'b1;
          ans_nxt_s     = ANS_TMO;
          alarm_nxt_s   = 1'b1;
          gnt_cpu_nxt_s = 1'b0;
          gnt_ch_nxt_s  = '0;
        end else begin
          done_nxt_s = 1'b0;
        end
      end
      ST_REL: begin
        if (relock_s) begin
          gnt_cpu_nxt_s = own_cpu_r;
          gnt_ch_nxt_s  = own_ch_r;
        end else if (!owner_req_s && !any_ans_s) begin
          busy_nxt_s = 1'b0;
        end else begin
          busy_nxt_s = 1'b1;
        end
      end
      default: begin
        gnt_cpu_nxt_s = 1'b0;
        gnt_ch_nxt_s  = '0;
        busy_nxt_s    = 1'b0;
      end
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge __clk) begin
    if (__rst) begin
      gnt_cpu_r <= 1'b0;
      gnt_ch_r  <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      ans_r     <= ANS_OK;
      alarm_r   <= 1'b0;
      cnt_r     <= 8'd0;
      ptr_r     <= 3'd0;
      own_cpu_r <= 1'b0;
      own_ch_r  <= '0;
    end else begin
      gnt_cpu_r <= gnt_cpu_nxt_s;
      gnt_ch_r  <= gnt_ch_nxt_s;
      busy_r    <= busy_nxt_s;
      done_r    <= done_nxt_s;
      ans_r     <= ans_nxt_s;
      alarm_r   <= alarm_nxt_s;
      cnt_r     <= cnt_nxt_s;
      ptr_r     <= ptr_nxt_s;
      own_cpu_r <= own_cpu_nxt_s;
      own_ch_r  <= own_ch_nxt_s;
    end
  end

  assign gnt_cpu  = gnt_cpu_r;
  assign gnt_ch   = gnt_ch_r;
  assign bus_busy = busy_r;
  assign done     = done_r;
  assign ans      = ans_r;
  assign alarm    = alarm_r;

endmodule

// File: tb/tb_sysbus_arb.sv
// Scoreboard bench for sysbus_arb: directed bus cycles push the expected
// owner/answer/alarm; a negedge monitor pops and compares on every done.
module tb_sysbus_arb;
  import mera_bus_pkg::*;

  typedef struct packed {
    logic [4:0] owner;
    logic [1:0] ans;
    logic       alarm;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_req, bus_ok, bus_en, bus_pe;
  logic [3:0] ch_req;
  logic       gnt_cpu, bus_busy, done, alarm;
  logic [3:0] gnt_ch;
  logic [1:0] ans;

  logic       cpu_req2, bus_ok2, bus_en2, bus_pe2;
  logic [3:0] ch_req2;
  logic       gnt_cpu2, bus_busy2, done2, alarm2;
  logic [3:0] gnt_ch2;
  logic [1:0] ans2;
`ifdef SYSBUS_ARB_LOCK_EN
  logic       lock, lock2;
`endif

  exp_t       sb_q[$];
  int         n_vec  = 0;
  int         n_fail = 0;
  logic [4:0] last_gnt = 5'd0;
  int         rr_seq[5] = '{1, 2, 3, 0, 1};

  sysbus_arb #(.NCH(4), .CPU_LAST(1'b1)) dut (
    .__clk(clk), .__rst(rst), .cpu_req(cpu_req), .ch_req(ch_req),
    .bus_ok(bus_ok), .bus_en(bus_en), .bus_pe(bus_pe),
`ifdef SYSBUS_ARB_LOCK_EN
    .lock(lock),
`endif
    .gnt_cpu(gnt_cpu), .gnt_ch(gnt_ch), .bus_busy(bus_busy),
    .done(done), .ans(ans), .alarm(alarm)
  );

  sysbus_arb #(.NCH(4), .CPU_LAST(1'b0)) dut_cpu_first (
    .__clk(clk), .__rst(rst), .cpu_req(cpu_req2), .ch_req(ch_req2),
    .bus_ok(bus_ok2), .bus_en(bus_en2), .bus_pe(bus_pe2),
`ifdef SYSBUS_ARB_LOCK_EN
    .lock(lock2),
`endif
    .gnt_cpu(gnt_cpu2), .gnt_ch(gnt_ch2), .bus_busy(bus_busy2),
    .done(done2), .ans(ans2), .alarm(alarm2)
  );

  initial forever #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One bus cycle: wait for grant, answer at WAIT tick nwait, land on the done tick.
  task automatic serve(input logic [4:0] owner, input int nwait, input logic [2:0] pe_en_ok,
                       input logic [1:0] exp_ans, input logic exp_alarm, input bit hold);
    int   n;
    exp_t e;
    n = 0;
    while ({gnt_cpu, gnt_ch} == 5'd0 && n < 20) begin
      cyc(1);
      n++;
    end
    chk("grant_owner", 32'({gnt_cpu, gnt_ch}), 32'(owner));
    chk("busy_in_grant", 32'(bus_busy), 32'd1);
    e.owner = owner;
    e.ans   = exp_ans;
    e.alarm = exp_alarm;
    sb_q.push_back(e);
    cyc(nwait);
    chk("grant_held_no_done", 32'({gnt_cpu, gnt_ch, done}), 32'({owner, 1'b0}));
    {bus_pe, bus_en, bus_ok} = pe_en_ok;
    cyc(1);
    chk("done_tick", 32'({done, gnt_cpu, gnt_ch}), 32'({1'b1, 5'd0}));
    if (!hold) begin
      {bus_pe, bus_en, bus_ok} = 3'b000;
    end
  endtask

  // Monitor: checks grant exclusivity and scores every done against the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if ({gnt_cpu, gnt_ch} != 5'd0) begin
        chk("grant_onehot", 32'($onehot({gnt_cpu, gnt_ch})), 32'd1);
        last_gnt = {gnt_cpu, gnt_ch};
      end
      if (done === 1'b1) begin
        chk("done_expected", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk("sb_owner", 32'(last_gnt), 32'(e.owner));
          chk("sb_ans", 32'(ans), 32'(e.ans));
          chk("sb_alarm", 32'(alarm), 32'(e.alarm));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: no summary by %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    {cpu_req, bus_ok, bus_en, bus_pe} = 4'b0000;
    ch_req = 4'b0000;
    {cpu_req2, bus_ok2, bus_en2, bus_pe2} = 4'b0000;
    ch_req2 = 4'b0000;
`ifdef SYSBUS_ARB_LOCK_EN
    lock  = 1'b0;
    lock2 = 1'b0;
`endif
    cyc(3);
    chk("reset_outputs", 32'({gnt_cpu, gnt_ch, bus_busy, done, ans, alarm}), 32'd0);
    rst = 1'b0;
    cyc(1);

    // CPU only: OK at WAIT tick 3, busy stays until cpu_req falls.
    cpu_req = 1'b1;
    serve(5'b10000, 3, 3'b001, ANS_OK, 1'b0, 1'b0);
    cyc(1);
    chk("busy_while_req_held", 32'({bus_busy, gnt_cpu}), 32'b10);
    cpu_req = 1'b0;
    cyc(1);
    chk("busy_after_req_drop", 32'(bus_busy), 32'd0);

    // Round-robin with all channels requesting.
    ch_req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      serve(5'(1 << rr_seq[i]), i + 1, 3'b001, ANS_OK, 1'b0, 1'b0);
      ch_req[rr_seq[i]] = 1'b0;
      if (i < 4) begin
        cyc(2);
        ch_req[rr_seq[i]] = 1'b1;
      end else begin
        ch_req = 4'b0000;
        cyc(2);
      end
    end

    // Channel beats CPU on a tie; EN alone, then OK+PE clash.
    cpu_req = 1'b1;
    ch_req  = 4'b0100;
    serve(5'b00100, 2, 3'b010, ANS_EN, 1'b0, 1'b0);
    ch_req = 4'b0000;
    serve(5'b10000, 1, 3'b101, ANS_PE, 1'b0, 1'b0);
    cpu_req = 1'b0;
    cyc(2);

    // Answer held high in REL blocks the return to IDLE.
    cpu_req = 1'b1;
    serve(5'b10000, 2, 3'b100, ANS_PE, 1'b0, 1'b1);
    cpu_req = 1'b0;
    cyc(2);
    chk("busy_answer_held", 32'(bus_busy), 32'd1);
    bus_pe = 1'b0;
    cyc(1);
    chk("busy_answer_dropped", 32'(bus_busy), 32'd0);

    // Timeout on ch0, then a CPU cycle keeps the sticky alarm.
    ch_req = 4'b0001;
    serve(5'b00001, 200, 3'b000, ANS_TMO, 1'b1, 1'b0);
    ch_req = 4'b0000;
    cyc(2);
    cpu_req = 1'b1;
    serve(5'b10000, 2, 3'b001, ANS_OK, 1'b1, 1'b0);
    cpu_req = 1'b0;
    cyc(2);
    chk("alarm_sticky", 32'({alarm, ans}), 32'({1'b1, ANS_OK}));

    // Reset during WAIT: everything drops, no done, alarm cleared.
    cpu_req = 1'b1;
    cyc(1);
    chk("grant_before_reset", 32'(gnt_cpu), 32'd1);
    cyc(2);
    rst = 1'b1;
    cyc(1);
    chk("reset_mid_wait", 32'({gnt_cpu, gnt_ch, bus_busy, done, ans, alarm}), 32'd0);
    rst = 1'b0;
    cpu_req = 1'b0;
    cyc(3);

    // Pointer back to 0 after reset: lone ch3 wins, alarm clear.
    ch_req = 4'b1000;
    serve(5'b01000, 4, 3'b001, ANS_OK, 1'b0, 1'b0);
    ch_req = 4'b0000;
    cyc(2);

`ifdef SYSBUS_ARB_LOCK_EN
    // Locked CPU keeps the bus despite a waiting channel.
    lock    = 1'b1;
    cpu_req = 1'b1;
    serve(5'b10000, 1, 3'b001, ANS_OK, 1'b0, 1'b0);
    ch_req = 4'b0010;
    serve(5'b10000, 1, 3'b001, ANS_OK, 1'b0, 1'b0);
    cpu_req = 1'b0;
    lock    = 1'b0;
    serve(5'b00010, 1, 3'b001, ANS_OK, 1'b0, 1'b0);
    ch_req = 4'b0000;
    cyc(2);
`endif

    // CPU_LAST=0 instance: CPU wins the tie, channel follows.
    cpu_req2 = 1'b1;
    ch_req2  = 4'b0100;
    cyc(1);
    chk("cpu_first_grant", 32'({gnt_cpu2, gnt_ch2}), 32'b10000);
    cyc(1);
    bus_ok2 = 1'b1;
    cyc(1);
    chk("cpu_first_done", 32'({done2, ans2}), 32'({1'b1, ANS_OK}));
    bus_ok2  = 1'b0;
    cpu_req2 = 1'b0;
    cyc(2);
    chk("cpu_first_then_ch", 32'({gnt_cpu2, gnt_ch2}), 32'b00100);
    cyc(1);
    bus_ok2 = 1'b1;
    cyc(1);
    chk("cpu_first_ch_done", 32'(done2), 32'd1);
    bus_ok2 = 1'b0;
    ch_req2 = 4'b0000;
    cyc(2);
    chk("cpu_first_idle", 32'({bus_busy2, alarm2}), 32'd0);

    cyc(3);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/sysbus_arb.md
Name: sysbus_arb

Overview:
- Arbiter and cycle sequencer for the shared system bus (memory/interface cycles).
- Shares the bus between the CPU micro-sequencer and NCH I/O channel requesters.
- Owns one bus transaction at a time: grant → wait for answer (OK / EN / PE) or timeout → release.
- Reports the answer back to the granted requester. Sits between the P-M/P-R CPU units, the channel adapters and the bus interface drivers.

Parameters:
- NCH, 4, number of channel requesters (1..8).
- TMO, 8'd200, answer-timeout in __clk ticks (200 = 4 µs @ 50 MHz).
- CPU_LAST, 1, 1: channels win over CPU on a simultaneous request; 0: CPU wins.

Ports:
- __clk  in  1  system clock, 50 MHz
- __rst  in  1  synchronous reset, active-high
- cpu_req  in  1  CPU requests a bus cycle; held until cpu_done seen
- ch_req  in  NCH  per-channel request; each held until its done seen
- bus_ok  in  1  answer: cycle accepted (OK)
- bus_en  in  1  answer: device/memory absent (EN, "engaged/none")
- bus_pe  in  1  answer: parity error
- lock  in  1  (only with SYSBUS_ARB_LOCK_EN) keep current owner for the next cycle
- gnt_cpu  out  1  CPU owns bus and may drive it
- gnt_ch  out  NCH  one-hot channel grant
- bus_busy  out  1  transaction in progress
- done  out  1  one-tick pulse to the owner; answer below is valid in the same tick
- ans  out  2  answer code: 0 OK, 1 EN, 2 PE, 3 timeout
- alarm  out  1  sticky "no answer" alarm; cleared only by __rst

Behaviour:
- All state changes on the rising edge of __clk. __rst overrides everything.
- Reset values: all outputs 0, state IDLE, round-robin pointer 0, timeout counter 0.
- States and transitions:
  - IDLE: on any request, pick the winner, assert its grant next tick → GRANT.
  - GRANT: grant held one tick (address/data setup), bus_busy=1 → WAIT; counter cleared.
  - WAIT: counter increments each tick.
    - Answer priority when several are sampled in the same tick: PE > EN > OK.
    - On an answer: done=1 for one tick, ans set, grant dropped → REL.
    - If the counter reaches TMO with no answer: ans=3, done=1, alarm=1 → REL.
  - REL: wait until the owner's request is low and bus_ok/bus_en/bus_pe are all low, then bus_busy=0 → IDLE.
- Minimum cycle is 4 ticks (IDLE/GRANT/WAIT/REL).
- Grant vectors are one-hot or zero; gnt_cpu and gnt_ch are never asserted together.
- Channel selection is round-robin: search starts at pointer+1, modulo NCH. After a channel grant the pointer is set to that channel index; wrap NCH-1 → 0.
- CPU versus channels on simultaneous requests follows CPU_LAST. Even with CPU_LAST=1, the CPU wins if no channel requests.
- A request that drops before grant is ignored; no grant is issued.
- An answer arriving in GRANT is ignored; only WAIT samples answers.
- ans holds its value until the next done.
- Requests arriving during WAIT/REL are queued implicitly; arbitration is re-evaluated in IDLE only.
- __rst mid-transaction: grants drop on the next edge, no done is issued, alarm is cleared.

Optional Feature:
- Macro: SYSBUS_ARB_LOCK_EN.
- Defined:
  - lock sampled in REL. If lock=1 and the owner re-asserts its request, REL → GRANT directly for the same owner, skipping arbitration; the pointer is unchanged.
  - lock is ignored after a timeout.
  - Used for read-modify-write instructions (IB/MB-style).
- Undefined: the lock port does not exist; every cycle re-arbitrates.

Decomposition:
- Shared package mera_bus_pkg:
  - ans codes ANS_OK=2'd0, ANS_EN=2'd1, ANS_PE=2'd2, ANS_TMO=2'd3.
  - State enumeration ST_IDLE/ST_GRANT/ST_WAIT/ST_REL.
  - Default timeout constant.
- One sub-module rr_pick: combinational round-robin picker (request vector, pointer → one-hot winner + valid). The FSM and timeout counter stay in sysbus_arb.

Test Plan:
- CPU only: cpu_req=1, bus_ok at WAIT tick 3 → gnt_cpu ticks 1–4, done=1 with ans=0, bus_busy drops after cpu_req falls.
- Round-robin: ch_req=4'b1111 held, each requester deasserts after done, reasserts 2 ticks later → grant order ch1, ch2, ch3, ch0, ch1.
- Priority, both settings:
  - CPU_LAST=1 with cpu_req and ch_req[2] simultaneous → gnt_ch=4'b0100 first, then gnt_cpu.
  - CPU_LAST=0 → gnt_cpu first.
- Timeout: ch_req[0]=1, no answer → done at WAIT tick TMO, ans=3, alarm=1 sticky; next CPU cycle with bus_ok → ans=0, alarm still 1.
- Answer clash: bus_ok and bus_pe asserted in the same tick → ans=2. bus_en alone → ans=1. Answer held high in REL → no IDLE until it drops.
- Reset and lock:
  - __rst asserted during WAIT → all outputs 0 next tick, no done.
  - With SYSBUS_ARB_LOCK_EN: lock=1, CPU re-requests while ch_req[1]=1 → gnt_cpu again with no intervening channel grant.
